shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath; successor to the single-function combinational SLL unit. Supports logical left/right, arithmetic right, and rotate left/right on a WIDTH-bit operand. Two-stage registered pipeline with valid/ready handshakes on both sides, so it can be stalled by the ALU result mux/writeback without dropping operations.

---
 rtl/shifter_pkg.sv | 41 ++++
 rtl/shift_level.sv | 33 +++
 rtl/shifter_pipe.sv | 154 +++++++++++++++
 tb/tb_shifter_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - function codes and decode helpers for shifter_pipe
//
// Purpose: ALU shift function codes, the per-level operation encoding used
// inside the barrel, and helpers that decode a function code.
// Ports: none (package).
package shifter_pkg;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_ROR = 6'b000100;
  localparam logic [5:0] FN_ROL = 6'b000101;

  // Every barrel level only ever shifts right. Left ops reverse the
  // operand on entry and the result on exit.
  typedef enum logic [1:0] {
    LVL_SRL = 2'd0,
    LVL_SRA = 2'd1,
    LVL_ROR = 2'd2
  } level_op_e;

  function automatic logic fn_illegal(input logic [5:0] code);
    case (code)
      FN_SLL, FN_SRL, FN_SRA, FN_ROR, FN_ROL: fn_illegal = 1'b0;
      default:                                fn_illegal = 1'b1;
    endcase
  endfunction

  function automatic level_op_e fn_level_op(input logic [5:0] code);
    case (code)
      FN_SRA:         fn_level_op = LVL_SRA;
      FN_ROR, FN_ROL: fn_level_op = LVL_ROR;
      default:        fn_level_op = LVL_SRL;
    endcase
  endfunction

  function automatic logic fn_reversed(input logic [5:0] code);
    fn_reversed = (code == FN_SLL) || (code == FN_ROL);
  endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one combinational barrel level shifting right by DIST
//
// Purpose: passes data_in through unchanged, or shifts/rotates it right by
// DIST when enable is set.
// Ports:
//   data_in  [WIDTH-1:0]  operand from the previous level
//   enable                apply this level's distance
//   op       [1:0]        level_op_e: logical right, arithmetic right, rotate right
//   data_out [WIDTH-1:0]  result to the next level
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (enable) begin
      case (op)
        LVL_SRA: data_out = {{DIST{data_in[WIDTH-1]}}, data_in[WIDTH-1:DIST]};
        LVL_ROR: data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
        default: data_out = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - two-stage pipelined barrel shifter with valid/ready
//
// Purpose: SLL/SRL/SRA/ROR/ROL of inputA by inputB[SHW-1:0]. The lower half
// of the log levels sits before the stage-1 register, the rest before the
// output register. Unsupported codes produce out = 0, illegal = 1.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, inputA, inputB, SignalIn   request side
//   out_valid/out_ready, out, illegal              result side
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic [5:0]       SignalIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             illegal
);

  localparam int SHW       = $clog2(WIDTH);
  localparam int S1_LEVELS = SHW / 2;
  localparam int S2_LEVELS = SHW - S1_LEVELS;

  logic                 s1_valid_q,   s1_valid_d;
  logic [WIDTH-1:0]     s1_data_q,    s1_data_d;
  logic [S2_LEVELS-1:0] s1_amt_q,     s1_amt_d;
  logic [1:0]           s1_op_q,      s1_op_d;
  logic                 s1_rev_q,     s1_rev_d;
  logic                 s1_illegal_q, s1_illegal_d;
  logic                 out_valid_q,  out_valid_d;
  logic [WIDTH-1:0]     out_q,        out_d;
  logic                 illegal_q,    illegal_d;

  logic [SHW-1:0]   amt;
  logic [1:0]       in_op;
  logic             in_rev;
  logic [WIDTH-1:0] s1_front;
  logic [WIDTH-1:0] s2_result;
  logic [WIDTH-1:0] s1_chain [S1_LEVELS+1];
  logic [WIDTH-1:0] s2_chain [S2_LEVELS+1];
  logic             s2_load;
  logic             s1_load;
  logic             accept;

  // Only the low SHW bits of the shift amount matter.
  logic unused_inputb_hi;
  assign unused_inputb_hi = ^inputB[WIDTH-1:SHW];

  // Left ops run through the right-shifting barrel on a bit-reversed operand.
  always_comb begin
    amt      = inputB[SHW-1:0];
    in_op    = fn_level_op(SignalIn);
    in_rev   = fn_reversed(SignalIn);
    s1_front = inputA;
    if (in_rev) begin
      for (int i = 0; i < WIDTH; i++) s1_front[i] = inputA[WIDTH-1-i];
    end
  end

  assign s1_chain[0] = s1_front;

  for (genvar k = 0; k < S1_LEVELS; k++) begin : g_s1
    shift_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_lvl (
      .data_in  (s1_chain[k]),
      .enable   (amt[k]),
      .op       (in_op),
      .data_out (s1_chain[k+1])
    );
  end

  assign s2_chain[0] = s1_data_q;

  for (genvar k = 0; k < S2_LEVELS; k++) begin : g_s2
    shift_level #(.WIDTH(WIDTH), .DIST(1 << (S1_LEVELS + k))) u_lvl (
      .data_in  (s2_chain[k]),
      .enable   (s1_amt_q[k]),
      .op       (s1_op_q),
      .data_out (s2_chain[k+1])
    );
  end

  always_comb begin
    s2_result = s2_chain[S2_LEVELS];
    if (s1_rev_q) begin
      for (int i = 0; i < WIDTH; i++) s2_result[i] = s2_chain[S2_LEVELS][WIDTH-1-i];
    end
  end

  // in_ready depends on out_ready and the valid flops only, never on in_valid.
  always_comb begin
    s2_load = !out_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
    accept  = in_valid && s1_load;

    s1_valid_d   = s1_load ? in_valid : s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_amt_d     = s1_amt_q;
    s1_op_d      = s1_op_q;
    s1_rev_d     = s1_rev_q;
    s1_illegal_d = s1_illegal_q;
    if (accept) begin
      s1_data_d    = s1_chain[S1_LEVELS];
      s1_amt_d     = amt[SHW-1:S1_LEVELS];
      s1_op_d      = in_op;
      s1_rev_d     = in_rev;
      s1_illegal_d = fn_illegal(SignalIn);
    end

    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    out_d       = out_q;
    illegal_d   = illegal_q;
    if (s2_load && s1_valid_q) begin
      out_d     = s1_illegal_q ? '0 : s2_result;
      illegal_d = s1_illegal_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      illegal_q   <= illegal_d;
    end
  end

  // Stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_data_q    <= s1_data_d;
    s1_amt_q     <= s1_amt_d;
    s1_op_q      <= s1_op_d;
    s1_rev_q     <= s1_rev_d;
    s1_illegal_q <= s1_illegal_d;
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - self-checking bench for shifter_pipe
`timescale 1ns/1ps
module tb_shifter_pipe;

  localparam int W = 32;
  localparam logic [5:0] C_SLL = 6'b000000;
  localparam logic [5:0] C_SRL = 6'b000010;
  localparam logic [5:0] C_SRA = 6'b000011;
  localparam logic [5:0] C_ROR = 6'b000100;
  localparam logic [5:0] C_ROL = 6'b000101;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] inputA = '0;
  logic [W-1:0] inputB = '0;
  logic [5:0]   SignalIn = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         illegal;

  int n_checks = 0;
  int n_fail   = 0;
  int n_recv   = 0;

  logic [32:0] sb[$];
  bit          mon_en = 1'b0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_out;
  logic        hold_ill;

  always #5 clk = ~clk;

  shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inputA    (inputA),
    .inputB    (inputB),
    .SignalIn  (SignalIn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .illegal   (illegal)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: {illegal, out} straight from the operation definitions.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] f);
    logic [4:0]  n;
    logic [63:0] d;
    logic [63:0] t;
    logic [31:0] r;
    n = b[4:0];
    d = {a, a};
    case (f)
      C_SLL: r = a << n;
      C_SRL: r = a >> n;
      C_SRA: r = $signed(a) >>> n;
      C_ROR: begin t = d >> n; r = t[31:0];  end
      C_ROL: begin t = d << n; r = t[63:32]; end
      default: return {1'b1, 32'h0};
    endcase
    return {1'b0, r};
  endfunction

  // Per-cycle compare against the scoreboard; sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_v) begin
        chk("stall_valid",   64'(out_valid), 64'(1));
        chk("stall_out",     64'(out),       64'(hold_out));
        chk("stall_illegal", 64'(illegal),   64'(hold_ill));
      end
      chk("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'(0));
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("out",     64'(out),     64'(e[31:0]));
          chk("illegal", 64'(illegal), 64'(e[32]));
          n_recv++;
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_out = out;
      hold_ill = illegal;
      if (in_valid && in_ready) sb.push_back(model(inputA, inputB, SignalIn));
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    int guard;
    guard = 0;
    inputA = a; inputB = b; SignalIn = f; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 100) begin
        chk("send_timeout", 64'(0), 64'(1));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Single op on an idle pipe with out_ready high: literal result and latency.
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] f, input logic [31:0] exp_out, input logic exp_ill);
    int lat;
    out_ready = 1'b1;
    inputA = a; inputB = b; SignalIn = f; in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_accept"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat),     64'(2));
    chk({name, "_out"},     64'(out),     64'(exp_out));
    chk({name, "_illegal"}, 64'(illegal), 64'(exp_ill));
    @(posedge clk); #1;
  endtask

  logic [31:0] st_a [8] = '{32'h0000_00FF, 32'hF000_0000, 32'h8000_0000, 32'h1234_5678,
                            32'h1234_5678, 32'h0000_ABCD, 32'h7000_0000, 32'hDEAD_BEEF};
  logic [31:0] st_b [8] = '{32'd8, 32'd28, 32'd31, 32'd8, 32'd4, 32'd3, 32'h0000_003F, 32'd0};
  logic [5:0]  st_f [8] = '{C_SLL, C_SRL, C_SRA, C_ROR, C_ROL, 6'b000001, C_SRA, C_ROL};

  initial begin
    int recv0;
    int guard;

    chk("model_sll", 64'(model(32'h0000_0001, 32'd31, C_SLL)), 64'({1'b0, 32'h8000_0000}));
    chk("model_sra", 64'(model(32'h8000_00F0, 32'd4,  C_SRA)), 64'({1'b0, 32'hF800_000F}));
    chk("model_rol", 64'(model(32'h8000_0001, 32'd1,  C_ROL)), 64'({1'b0, 32'h0000_0003}));
    chk("model_ror", 64'(model(32'h1234_5678, 32'd8,  C_ROR)), 64'({1'b0, 32'h7812_3456}));

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out",       64'(out),       64'(0));
    chk("rst_illegal",   64'(illegal),   64'(0));
    #11 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    mon_en = 1'b1;

    directed("sll31",     32'h0000_0001, 32'd31,          C_SLL, 32'h8000_0000, 1'b0);
    directed("sra4",      32'h8000_00F0, 32'd4,           C_SRA, 32'hF800_000F, 1'b0);
    directed("srl4",      32'h8000_00F0, 32'd4,           C_SRL, 32'h0800_000F, 1'b0);
    directed("sra_hi",    32'h8000_00F0, 32'h0000_0024,   C_SRA, 32'hF800_000F, 1'b0);
    directed("srl_hi",    32'h8000_00F0, 32'h0000_0024,   C_SRL, 32'h0800_000F, 1'b0);
    directed("rol1",      32'h8000_0001, 32'd1,           C_ROL, 32'h0000_0003, 1'b0);
    directed("ror1",      32'h0000_0001, 32'd1,           C_ROR, 32'h8000_0000, 1'b0);
    directed("ror0",      32'hA5A5_1234, 32'd0,           C_ROR, 32'hA5A5_1234, 1'b0);
    directed("sll_n32",   32'hCAFE_F00D, 32'd32,          C_SLL, 32'hCAFE_F00D, 1'b0);
    directed("ror8",      32'h1234_5678, 32'd8,           C_ROR, 32'h7812_3456, 1'b0);
    directed("rol8",      32'h1234_5678, 32'd8,           C_ROL, 32'h3456_7812, 1'b0);
    directed("illegal20", 32'hFFFF_FFFF, 32'd5,           6'b100000, 32'h0, 1'b1);

    recv0 = n_recv;
    fork
      begin
        for (int i = 0; i < 8; i++) send(st_a[i], st_b[i], st_f[i]);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          if (c >= 3 && c < 8)  out_ready = 1'b0;
          else if (c < 30)      out_ready = 1'($urandom_range(0, 1));
          else                  out_ready = 1'b1;
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stream_count",  64'(n_recv - recv0), 64'(8));
    chk("stream_drained", 64'(sb.size()),     64'(0));

    out_ready = 1'b0;
    send(32'h0000_0011, 32'd1, C_SLL);
    send(32'h0000_0022, 32'd1, C_SRL);
    @(negedge clk);
    chk("full_in_ready",  64'(in_ready),  64'(0));
    chk("full_out_valid", 64'(out_valid), 64'(1));
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_out",       64'(out),       64'(0));
    chk("async_illegal",   64'(illegal),   64'(0));
    sb.delete();
    hold_v = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    directed("post_rst_sra", 32'hF000_0000, 32'd4, C_SRA, 32'hFF00_0000, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
